// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-port synchronous SRAM between
// the instruction-fetch port and the load/store data port, with one-deep response buffering per port.
`default_nettype none

module mem_arb #(
  parameter int AW  = 15,
  parameter int DW  = 32,
  parameter int PAW = 32
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           if_req_vld,
  output logic           if_req_rdy,
  input  logic [PAW-1:0] if_req_pc,
  output logic           if_rsp_vld,
  input  logic           if_rsp_rdy,
  output logic [DW-1:0]  if_rsp_ir,

  input  logic           d_req_vld,
  output logic           d_req_rdy,
  input  logic           d_req_wen,
  input  logic [PAW-1:0] d_req_addr,
  input  logic [DW-1:0]  d_req_wdata,
  output logic           d_rsp_vld,
  input  logic           d_rsp_rdy,
  output logic [DW-1:0]  d_rsp_rdata,

  output logic [AW-1:0]  sram_addr,
  output logic           sram_wen,
  output logic [DW-1:0]  sram_wdata,
  input  logic [DW-1:0]  sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } rsp_st_e;

  rsp_st_e       if_st_q;
  rsp_st_e       d_st_q;
  logic          last_d_q;
  logic          d_wr_q;
  logic [DW-1:0] if_hold_q;
  logic [DW-1:0] d_hold_q;

  logic if_elig;
  logic d_elig;
  logic if_gnt;
  logic d_gnt;

  // Byte-offset bits and bits above the SRAM range are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_pc[1:0], if_req_pc[PAW-1:AW+2],
                              d_req_addr[1:0], d_req_addr[PAW-1:AW+2]};

  always_comb begin
    if_elig = if_req_vld && ((if_st_q == ST_IDLE) || if_rsp_rdy);
    d_elig  = d_req_vld  && ((d_st_q  == ST_IDLE) || d_rsp_rdy);
    if_gnt  = rst_n && if_elig && (!d_elig || last_d_q);
    d_gnt   = rst_n && d_elig  && (!if_elig || !last_d_q);
  end

  assign if_req_rdy = if_gnt;
  assign d_req_rdy  = d_gnt;

  always_comb begin
    sram_addr  = '0;
    sram_wen   = 1'b0;
    sram_wdata = '0;
    if (if_gnt) begin
      sram_addr = if_req_pc[AW+1:2];
    end else if (d_gnt) begin
      sram_addr  = d_req_addr[AW+1:2];
      sram_wen   = d_req_wen;
      sram_wdata = d_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_st_q   <= ST_IDLE;
      d_st_q    <= ST_IDLE;
      last_d_q  <= 1'b1;
      d_wr_q    <= 1'b0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      if (if_gnt) begin
        last_d_q <= 1'b0;
      end else if (d_gnt) begin
        last_d_q <= 1'b1;
      end

      case (if_st_q)
        ST_PEND: begin
          if (!if_rsp_rdy) begin
            if_st_q   <= ST_HOLD;
            if_hold_q <= sram_rdata;
          end else if (!if_gnt) begin
            if_st_q <= ST_IDLE;
          end
        end
        ST_HOLD: if (if_rsp_rdy && !if_gnt) if_st_q <= ST_IDLE;
        default: ;
      endcase
      // A grant always wins: it is only possible when the previous response leaves this cycle.
      if (if_gnt) if_st_q <= ST_PEND;

      case (d_st_q)
        ST_PEND: begin
          if (!d_rsp_rdy) begin
            d_st_q   <= ST_HOLD;
            d_hold_q <= sram_rdata;
          end else if (!d_gnt) begin
            d_st_q <= ST_IDLE;
          end
        end
        ST_HOLD: if (d_rsp_rdy && !d_gnt) d_st_q <= ST_IDLE;
        default: ;
      endcase
      if (d_gnt) begin
        d_st_q <= ST_PEND;
        d_wr_q <= d_req_wen;
      end
    end
  end

  always_comb begin
    if_rsp_vld = (if_st_q != ST_IDLE);
    if_rsp_ir  = '0;
    if (if_st_q == ST_PEND)      if_rsp_ir = sram_rdata;
    else if (if_st_q == ST_HOLD) if_rsp_ir = if_hold_q;

    d_rsp_vld   = (d_st_q != ST_IDLE);
    d_rsp_rdata = '0;
    if (!d_wr_q) begin
      if (d_st_q == ST_PEND)      d_rsp_rdata = sram_rdata;
      else if (d_st_q == ST_HOLD) d_rsp_rdata = d_hold_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with an SRAM model and per-port response scoreboards.
`default_nettype none

module tb_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req_vld, if_req_rdy, if_rsp_vld, if_rsp_rdy;
  logic [31:0] if_req_pc, if_rsp_ir;
  logic        d_req_vld, d_req_rdy, d_req_wen, d_rsp_vld, d_rsp_rdy;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [14:0] sram_addr;
  logic        sram_wen;
  logic [31:0] sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram_mem [0:32767];
  logic [31:0] ref_mem  [0:32767];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];

  mem_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_vld (if_req_vld),
    .if_req_rdy (if_req_rdy),
    .if_req_pc  (if_req_pc),
    .if_rsp_vld (if_rsp_vld),
    .if_rsp_rdy (if_rsp_rdy),
    .if_rsp_ir  (if_rsp_ir),
    .d_req_vld  (d_req_vld),
    .d_req_rdy  (d_req_rdy),
    .d_req_wen  (d_req_wen),
    .d_req_addr (d_req_addr),
    .d_req_wdata(d_req_wdata),
    .d_rsp_vld  (d_rsp_vld),
    .d_rsp_rdy  (d_rsp_rdy),
    .d_rsp_rdata(d_rsp_rdata),
    .sram_addr  (sram_addr),
    .sram_wen   (sram_wen),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
    sram_rdata <= sram_mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on accepted responses first, then push the expectation for this cycle's grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      if_q.delete();
      d_q.delete();
    end else begin
      if (if_rsp_vld && if_rsp_rdy) begin
        chk("if_q_nonempty", {31'd0, if_q.size() != 0}, 32'd1);
        if (if_q.size() != 0) chk("if_rsp_ir", if_rsp_ir, if_q.pop_front());
      end
      if (d_rsp_vld && d_rsp_rdy) begin
        chk("d_q_nonempty", {31'd0, d_q.size() != 0}, 32'd1);
        if (d_q.size() != 0) chk("d_rsp_rdata", d_rsp_rdata, d_q.pop_front());
      end
      if (if_req_vld && if_req_rdy) if_q.push_back(ref_mem[if_req_pc[16:2]]);
      if (d_req_vld && d_req_rdy) begin
        if (d_req_wen) begin
          ref_mem[d_req_addr[16:2]] = d_req_wdata;
          d_q.push_back(32'd0);
        end else begin
          d_q.push_back(ref_mem[d_req_addr[16:2]]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      sram_mem[i] = (i * 32'h9E3779B1) + 32'h0000_1357;
      ref_mem[i]  = (i * 32'h9E3779B1) + 32'h0000_1357;
    end
    sram_mem[4] = 32'hDEADBEEF;
    ref_mem[4]  = 32'hDEADBEEF;

    // Reset with requests pending: grants must stay low
    rst_n = 1'b0;
    if_req_vld = 1'b1; if_req_pc = 32'h10; if_rsp_rdy = 1'b1;
    d_req_vld = 1'b1; d_req_wen = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h1;
    d_rsp_rdy = 1'b1;
    #2;
    chk("rst_if_rsp_vld", {31'd0, if_rsp_vld}, 32'd0);
    chk("rst_d_rsp_vld", {31'd0, d_rsp_vld}, 32'd0);
    chk("rst_if_rsp_ir", if_rsp_ir, 32'd0);
    chk("rst_d_rsp_rdata", d_rsp_rdata, 32'd0);
    chk("rst_sram_wen", {31'd0, sram_wen}, 32'd0);
    chk("rst_sram_addr", {17'd0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_if_req_rdy", {31'd0, if_req_rdy}, 32'd0);
    chk("rst_d_req_rdy", {31'd0, d_req_rdy}, 32'd0);
    smp();
    if_req_vld = 1'b0; d_req_vld = 1'b0; d_req_wen = 1'b0;
    #2 rst_n = 1'b1;

    // Uncontended fetch
    cyc();
    if_req_vld = 1'b1; if_req_pc = 32'h10;
    smp();
    chk("f_gnt", {31'd0, if_req_rdy}, 32'd1);
    chk("f_sram_addr", {17'd0, sram_addr}, 32'd4);
    chk("f_sram_wen", {31'd0, sram_wen}, 32'd0);
    chk("f_d_rdy", {31'd0, d_req_rdy}, 32'd0);
    cyc();
    if_req_vld = 1'b0;
    smp();
    chk("f_rsp_vld", {31'd0, if_rsp_vld}, 32'd1);
    chk("f_rsp_ir", if_rsp_ir, 32'hDEADBEEF);

    // Write then read the same word
    cyc();
    d_req_vld = 1'b1; d_req_wen = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h12345678;
    smp();
    chk("w_gnt", {31'd0, d_req_rdy}, 32'd1);
    chk("w_sram_wen", {31'd0, sram_wen}, 32'd1);
    chk("w_sram_addr", {17'd0, sram_addr}, 32'd8);
    chk("w_sram_wdata", sram_wdata, 32'h12345678);
    cyc();
    d_req_wen = 1'b0;
    smp();
    chk("w_ack_vld", {31'd0, d_rsp_vld}, 32'd1);
    chk("w_ack_data", d_rsp_rdata, 32'd0);
    chk("r_gnt", {31'd0, d_req_rdy}, 32'd1);
    chk("r_sram_wen", {31'd0, sram_wen}, 32'd0);
    cyc();
    d_req_vld = 1'b0;
    smp();
    chk("r_data", d_rsp_rdata, 32'h12345678);

    // Contention: grants alternate starting with fetch
    cyc();
    if_req_vld = 1'b1; if_req_pc = 32'h40;
    d_req_vld = 1'b1; d_req_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("cont_if_gnt", {31'd0, if_req_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_d_gnt", {31'd0, d_req_rdy}, (i % 2 == 0) ? 32'd0 : 32'd1);
      cyc();
    end

    // Back-pressure on fetch while data reads proceed
    if_req_pc = 32'h10; if_rsp_rdy = 1'b0; d_req_vld = 1'b0;
    smp();
    chk("bp_if_gnt", {31'd0, if_req_rdy}, 32'd1);
    cyc();
    d_req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_req_addr = 32'h100 + 32'(4 * i);
      smp();
      chk("bp_if_vld", {31'd0, if_rsp_vld}, 32'd1);
      chk("bp_if_ir", if_rsp_ir, 32'hDEADBEEF);
      chk("bp_if_rdy", {31'd0, if_req_rdy}, 32'd0);
      chk("bp_d_gnt", {31'd0, d_req_rdy}, 32'd1);
      chk("bp_sram_addr", {17'd0, sram_addr}, 32'h40 + 32'(i));
      cyc();
    end

    // Accept from HOLD and reissue in the same cycle
    d_req_vld = 1'b0; if_rsp_rdy = 1'b1; if_req_pc = 32'h44;
    smp();
    chk("ar_gnt", {31'd0, if_req_rdy}, 32'd1);
    chk("ar_old_ir", if_rsp_ir, 32'hDEADBEEF);
    cyc();
    if_req_vld = 1'b0;
    smp();
    chk("ar_vld", {31'd0, if_rsp_vld}, 32'd1);
    chk("ar_new_ir", if_rsp_ir, ref_mem[17]);

    // Reset while a data response is stalled
    cyc();
    d_req_vld = 1'b1; d_req_wen = 1'b0; d_req_addr = 32'h200; d_rsp_rdy = 1'b0;
    smp();
    chk("rm_gnt", {31'd0, d_req_rdy}, 32'd1);
    cyc();
    if_req_vld = 1'b1; if_req_pc = 32'h48;
    smp();
    chk("rm_vld_before", {31'd0, d_rsp_vld}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_d_vld", {31'd0, d_rsp_vld}, 32'd0);
    chk("rm_d_rdata", d_rsp_rdata, 32'd0);
    chk("rm_d_rdy", {31'd0, d_req_rdy}, 32'd0);
    chk("rm_if_rdy", {31'd0, if_req_rdy}, 32'd0);
    smp();
    cyc();
    d_rsp_rdy = 1'b1; if_req_pc = 32'h4C; d_req_addr = 32'h204;
    rst_n = 1'b1;
    smp();
    chk("post_if_gnt", {31'd0, if_req_rdy}, 32'd1);
    chk("post_d_gnt", {31'd0, d_req_rdy}, 32'd0);
    cyc();
    smp();
    chk("post2_d_gnt", {31'd0, d_req_rdy}, 32'd1);
    chk("post2_if_gnt", {31'd0, if_req_rdy}, 32'd0);
    cyc();
    if_req_vld = 1'b0; d_req_vld = 1'b0;
    smp();
    smp();
    chk("if_q_drained", if_q.size(), 32'd0);
    chk("d_q_drained", d_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares one single-port synchronous SRAM between the core's instruction-fetch path and its load/store data path. It presents an `ifetch_if_t` slave to the fetch unit, a valid/ready data port to the execute stage, and drives the SRAM as an `sram_if_t` master. It performs round-robin arbitration, converts byte addresses to SRAM word addresses, and buffers one response per port so that back-pressure never stalls the other requester.

## Interface
- AW, 15, SRAM word-address width
- DW, 32, data / instruction width
- PAW, 32, byte-address width of requester ports
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_vld  in  1  fetch request valid
- if_req_rdy  out  1  fetch request accepted (grant)
- if_req_pc  in  PAW  fetch byte address
- if_rsp_vld  out  1  instruction valid
- if_rsp_rdy  in  1  fetch unit accepts instruction
- if_rsp_ir  out  DW  instruction word
- d_req_vld  in  1  data request valid
- d_req_rdy  out  1  data request accepted (grant)
- d_req_wen  in  1  1 = write, 0 = read
- d_req_addr  in  PAW  data byte address
- d_req_wdata  in  DW  write data
- d_rsp_vld  out  1  data response valid (read data or write ack)
- d_rsp_rdy  in  1  requester accepts response
- d_rsp_rdata  out  DW  read data; 0 for write acks
- sram_addr  out  AW  SRAM word address
- sram_wen  out  1  SRAM write enable
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM read data, valid the cycle after a read address is presented

## Operation
- Each port has a response FSM with three states. IDLE: no response. PEND: the request was granted last cycle, so rsp_vld=1 and the data is taken directly from sram_rdata. HOLD: rsp_vld=1 and the data is taken from the port's hold register.
- FSM transitions:
  - Grant moves the port to PEND.
  - PEND with rsp_rdy=1 and no new grant moves to IDLE.
  - PEND with rsp_rdy=0 moves to HOLD and captures sram_rdata into the hold register.
  - HOLD with rsp_rdy=1 and no new grant moves to IDLE.
  - PEND or HOLD with rsp_rdy=1 and a new grant moves to PEND.
- Eligibility: `req_vld && (state==IDLE || rsp_rdy)`. A port whose response is stalled is never granted.
- Arbitration:
  - If only one port is eligible, it is granted.
  - If both are eligible, grant the port that was not granted most recently.
  - The last-grant pointer updates only on a grant. Its reset value is "data", so fetch wins the first tie.
- req_rdy equals that port's grant, combinationally. Both grant signals are forced to 0 while rst_n=0.
- SRAM drive:
  - Fetch grant: sram_addr=if_req_pc[AW+1:2], sram_wen=0.
  - Data grant: sram_addr=d_req_addr[AW+1:2], sram_wen=d_req_wen, sram_wdata=d_req_wdata.
  - No grant: sram_addr=0, sram_wen=0, sram_wdata=0.
- Address bits [1:0] and bits above AW+1 are ignored. No misalignment or range error is reported.
- Writes take effect at the grant edge. The data port still receives one response (ack) with d_rsp_rdata=0. A per-port write flag is latched at grant.
- rsp data outputs are 0 whenever rsp_vld=0.

## Timing
- Reset (async assert) sets both FSMs to IDLE, last-grant pointer to data, and the hold registers to 0.
- Reset output values: if_rsp_vld=0, d_rsp_vld=0, if_rsp_ir=0, d_rsp_rdata=0, sram_wen=0, sram_addr=0, sram_wdata=0, if_req_rdy=0, d_req_rdy=0.
- Reset asserted mid-transaction drops any in-flight response. A write granted at the edge coincident with reset assertion is not guaranteed.
- Latency: a request granted in cycle N has rsp_vld=1 in cycle N+1.
- Throughput is one transaction per port per cycle while uncontended and rsp_rdy=1. Under contention with both ports continuously eligible, grants strictly alternate.
- A response, once valid, holds rsp_vld and data stable until accepted, regardless of later SRAM activity on the other port.
- Simultaneous response acceptance and new grant on the same port is allowed; the port stays valid with the new data in the next cycle.
- No combinational path runs from rsp_rdy to rsp_vld or rsp data. A combinational path from rsp_rdy to req_rdy is permitted.

## Test plan
- Uncontended fetch: preload SRAM word 4 = 0xDEADBEEF, set if_req_vld=1 with pc=0x10 and if_rsp_rdy=1 -> if_req_rdy=1 in cycle 0, sram_addr=4, sram_wen=0; in cycle 1 if_rsp_vld=1 and if_rsp_ir=0xDEADBEEF.
- Write then read: data write addr=0x20, wdata=0x12345678 -> ack in next cycle with d_rsp_rdata=0; a following read of 0x20 returns 0x12345678 one cycle after its grant.
- Contention: both ports request every cycle with rsp_rdy=1 from reset -> grants follow fetch, data, fetch, data; each port's responses match the SRAM contents at the issued addresses.
- Back-pressure: fetch granted with if_rsp_rdy=0 for 3 cycles while the data port issues reads to other addresses -> if_rsp_ir stays at the original word for all 3 cycles, if_req_rdy=0 during the stall, and the data port is granted every cycle.
- Accept-and-reissue: port in HOLD, rsp_rdy=1 with a new request in the same cycle -> request granted; next cycle shows rsp_vld=1 with the new data and no bubble.
- Reset mid-flight: assert rst_n=0 while d_rsp_vld=1 -> d_rsp_vld=0 and both req_rdy=0 immediately (asynchronously); after release the first tie is granted to fetch.
